// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4,
  parameter int ID_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr,
  output logic [DATA_W-1:0]         data_in,
  input  logic                      full,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d, last_id_q, last_id_d, pick, idx;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic found, busy, cur_valid;
  logic [DATA_W-1:0] data_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end
  assign busy        = state_q == GRANT;
  assign cur_valid   = req_valid[grant_id_q];
  assign grant_valid = busy;
  assign grant_id    = grant_id_q;
  // an in-flight beat during reset must not reach the FIFO nor be acknowledged
  assign wr          = busy & cur_valid & ~full & ~rst;
  assign req_ready   = (busy & ~full & ~rst) ? NUM_REQ'(1) << grant_id_q : '0;
  assign data_in     = busy ? data_arr[grant_id_q] : '0;
  always_comb begin
    pick  = last_id_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_id_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
    if (!busy) begin
      if (|req_valid) begin
        state_d    = GRANT;
        grant_id_d = pick;
        beat_cnt_d = '0;
      end
    end else if (!cur_valid) begin
      state_d   = IDLE;
      last_id_d = grant_id_q;
    end else if (!full) begin
      beat_cnt_d = beat_cnt_q + 8'd1;
      if (beat_cnt_q == 8'(BURST_LEN - 1)) begin
        state_d   = IDLE;
        last_id_d = grant_id_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_id_q  <= ID_W'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous FIFO write port between NUM_REQ producers. Each producer presents data on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to BURST_LEN beats and drives the FIFO `wr`/`data_in` pins. It sits directly in front of the FIFO and respects its `full` flag; the FIFO read side is untouched.

## Interface
- NUM_REQ, 4, number of producers (2..16)
- DATA_W, 8, data width; matches FIFO `data_in`
- BURST_LEN, 4, max beats per grant (1..255)
- ID_W, derived = max(1, clog2(NUM_REQ)), grant index width

- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-producer valid; bit i = producer i
- req_data  in  NUM_REQ*DATA_W  producer i data at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-producer accept; beat transfers when valid & ready in the same cycle
- wr  out  1  FIFO write enable
- data_in  out  DATA_W  FIFO write data
- full  in  1  FIFO full flag
- grant_valid  out  1  a producer currently holds the grant (state GRANT)
- grant_id  out  ID_W  index of granted producer; meaningful only when grant_valid=1

## Operation
- FSM states: IDLE, GRANT. Registered: state, grant_id, last_id (ID_W), beat_cnt (8 bits).
- IDLE: if any req_valid bit is set, select the first set bit searching last_id+1, last_id+2, ... modulo NUM_REQ. Load grant_id, set beat_cnt=0, go to GRANT. Otherwise stay in IDLE.
- GRANT, combinational:
  - req_ready[grant_id] = ~full; all other req_ready bits = 0.
  - wr = req_valid[grant_id] & ~full.
  - data_in = req_data slice of grant_id.
- GRANT, accepted beat (wr=1): beat_cnt increments.
  - If beat_cnt == BURST_LEN-1 at that edge: last_id <= grant_id, go to IDLE.
- GRANT with req_valid[grant_id]=0: release immediately. last_id <= grant_id, go to IDLE. Applies with any beat_cnt, including 0, and regardless of full.
- GRANT with full=1 and valid=1: hold the grant. No beat counted, no timeout. The producer stalls until full drops.
- Outside GRANT: all req_ready=0, wr=0, data_in=0, grant_valid=0.
- Producers must hold valid and data stable until accepted. The arbiter does not buffer data: a beat is written in the same cycle it is accepted.
- The arbiter never asserts wr while full=1, so FIFO overflow is impossible.
- Requests from non-granted producers are ignored until the next IDLE arbitration. No starvation: every valid producer is granted within NUM_REQ grants.

## Timing
- Reset (rst=1 at posedge): state=IDLE, last_id=NUM_REQ-1 (producer 0 wins first), grant_id=0, beat_cnt=0.
  - Outputs after reset: wr=0, data_in=0, req_ready=0, grant_valid=0.
  - Applies mid-burst: the in-flight beat in the reset cycle is not written (wr forced 0 while rst=1).
- Arbitration latency: valid seen in IDLE at edge k gives grant_valid=1 in cycle k+1. The first beat can be written in cycle k+1.
- One idle bubble cycle between consecutive grants, including a back-to-back grant to the same producer.
- Throughput: BURST_LEN beats per BURST_LEN+1 cycles with full=0 and all producers valid.
- `full` is used combinationally in the same cycle; there is no almost-full lookahead.
- `full` toggling mid-burst only inserts stall cycles; it does not change beat_cnt.

## Test plan
- Single producer: reset; req_valid=4'b0001, data 0x10..0x17, full=0.
  - Expect wr in cycles 1-4, bubble, then cycles 6-9.
  - FIFO contents 0x10..0x17 in order; grant_id=0 throughout.
- Round-robin: all four producers valid continuously, BURST_LEN=4.
  - Expect grant order 0,1,2,3,0, with 4 beats each and 1 bubble between grants.
  - No req_ready on a non-granted producer.
- Full backpressure: producer 2 granted; full=1 for 3 cycles after beat 1.
  - Expect wr=0 and req_ready[2]=0 during those cycles; beat_cnt holds at 1.
  - Beats 2-4 follow once full drops; no overflow.
- Early release: producer 1 granted; producer 1 drops valid after 2 beats while producer 3 is valid.
  - Expect return to IDLE, then grant_id=3 next cycle.
  - Exactly 2 writes from producer 1.
- Reset mid-burst: assert rst during beat 3 of producer 0.
  - Expect wr=0 in that cycle and all outputs 0 the next cycle.
  - After release with all producers valid, producer 0 is granted first.
- Wrap search: last_id=3, only producer 1 valid.
  - Expect grant_id=1, skipping producers 0 and 2; grant_valid high one cycle after valid.
